// File: rtl/mps_fmt_pkg.sv
// Shared types and word-format constants for the MPS readout frame formatter.
package mps_fmt_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StHdr,
    StReq,
    StW1,
    StW2,
    StHit,
    StTrl
  } fmt_state_e;

  localparam logic [7:0] HDR_MARK = 8'hBC;
  localparam logic [7:0] HIT_MARK = 8'hA5;
  localparam logic [7:0] TRL_MARK = 8'hFC;

  localparam int unsigned TRL_PAR_LSB  = 16;
  localparam int unsigned TRL_OVF_BIT  = 15;
  localparam int unsigned TRL_LOST_BIT = 14;
  localparam int unsigned TRL_CNT_LSB  = 0;

  function automatic logic [31:0] trailer_word(logic [7:0] par, logic ovf, logic lost,
                                               logic [7:0] cnt);
    logic [31:0] w;
    w                       = '0;
    w[31:24]                = TRL_MARK;
    w[TRL_PAR_LSB +: 8]     = par;
    w[TRL_OVF_BIT]          = ovf;
    w[TRL_LOST_BIT]         = lost;
    w[TRL_CNT_LSB +: 8]     = cnt;
    return w;
  endfunction

endpackage

// File: rtl/mps_readout_formatter.sv
// Pops hit addresses from the pixel FIFO and emits header/hit/trailer frames on a valid/ready
// stream. Define MPS_FMT_PARITY_EN to carry an XOR of all hit-address bytes in the trailer.
module mps_readout_formatter
  import mps_fmt_pkg::*;
#(
  parameter int unsigned MAX_HITS    = 255,
  parameter int unsigned FRAME_CNT_W = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_start,
  input  logic        fifo_empty,
  input  logic [23:0] fifo_data,
  output logic        fifo_rd,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy
);

  localparam logic [7:0]             MaxHitsB = 8'(MAX_HITS);
  localparam logic [FRAME_CNT_W-1:0] FrameInc = FRAME_CNT_W'(1);

  // Header counter field is 16 bits wide; FRAME_CNT_W is expected to be <= 16.
  function automatic logic [31:0] header_word(logic [FRAME_CNT_W-1:0] cnt);
    logic [31:0] w;
    w                    = {HDR_MARK, 24'h000000};
    w[FRAME_CNT_W-1:0]   = cnt;
    return w;
  endfunction

  fmt_state_e              state_q, state_d;
  logic [FRAME_CNT_W-1:0]  frame_cnt_q, frame_cnt_d;
  logic [7:0]              hit_cnt_q, hit_cnt_d;
  logic                    overflow_q, overflow_d;
  logic                    trig_lost_q, trig_lost_d;
  logic                    pending_q, pending_d;
  logic [31:0]             out_data_q, out_data_d;
  logic                    out_valid_q, out_valid_d;
  logic                    fifo_rd_q, fifo_rd_d;
  logic                    busy_q, busy_d;
  logic                    xfer;
  logic                    hdr_load;
  logic [7:0]              par_cur;

  assign xfer = out_valid_q & out_ready;

`ifdef MPS_FMT_PARITY_EN
  logic [7:0] parity_q, parity_d;

  always_comb begin
    parity_d = parity_q;
    if (hdr_load) begin
      parity_d = 8'h00;
    end else if (state_q == StW2) begin
      parity_d = parity_q ^ fifo_data[7:0] ^ fifo_data[15:8] ^ fifo_data[23:16];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) parity_q <= 8'h00;
    else       parity_q <= parity_d;
  end

  assign par_cur = parity_q;
`else
  assign par_cur = 8'h00;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      frame_cnt_q <= '0;
      hit_cnt_q   <= 8'h00;
      overflow_q  <= 1'b0;
      trig_lost_q <= 1'b0;
      pending_q   <= 1'b0;
      out_data_q  <= 32'h0;
      out_valid_q <= 1'b0;
      fifo_rd_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      frame_cnt_q <= frame_cnt_d;
      hit_cnt_q   <= hit_cnt_d;
      overflow_q  <= overflow_d;
      trig_lost_q <= trig_lost_d;
      pending_q   <= pending_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      fifo_rd_q   <= fifo_rd_d;
      busy_q      <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (frame_start) state_d = StHdr;
      StHdr:   if (xfer) state_d = StReq;
      StReq:   state_d = (hit_cnt_q == MaxHitsB || fifo_empty) ? StTrl : StW1;
      StW1:    state_d = StW2;
      StW2:    state_d = StHit;
      StHit:   if (xfer) state_d = StReq;
      StTrl:   if (xfer) state_d = (pending_q || frame_start) ? StHdr : StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    hit_cnt_d   = hit_cnt_q;
    overflow_d  = overflow_q;
    trig_lost_d = trig_lost_q;
    pending_d   = pending_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    fifo_rd_d   = 1'b0;
    busy_d      = busy_q;
    hdr_load    = 1'b0;

    // A trigger mid-frame queues one frame; a second one can only be reported.
    if (frame_start && state_q != StIdle) begin
      if (pending_q) trig_lost_d = 1'b1;
      else           pending_d   = 1'b1;
    end

    unique case (state_q)
      StIdle: if (frame_start) hdr_load = 1'b1;
      StHdr:  if (xfer) out_valid_d = 1'b0;
      StReq: begin
        if (hit_cnt_q == MaxHitsB || fifo_empty) begin
          if (hit_cnt_q == MaxHitsB) overflow_d = ~fifo_empty;
          out_data_d  = trailer_word(par_cur, overflow_d, trig_lost_d, hit_cnt_q);
          out_valid_d = 1'b1;
        end else begin
          fifo_rd_d = 1'b1;
        end
      end
      StW1: ;
      StW2: begin
        out_data_d  = {HIT_MARK, fifo_data};
        out_valid_d = 1'b1;
        hit_cnt_d   = hit_cnt_q + 8'd1;
      end
      StHit:  if (xfer) out_valid_d = 1'b0;
      StTrl: begin
        if (xfer) begin
          frame_cnt_d = frame_cnt_q + FrameInc;
          trig_lost_d = 1'b0;
          if (pending_q || frame_start) begin
            // A trigger landing on the trailer transfer stays queued behind the pending one.
            pending_d = pending_q & frame_start;
            hdr_load  = 1'b1;
          end else begin
            out_valid_d = 1'b0;
            busy_d      = 1'b0;
          end
        end
      end
      default: ;
    endcase

    if (hdr_load) begin
      out_data_d  = header_word(frame_cnt_d);
      out_valid_d = 1'b1;
      busy_d      = 1'b1;
      hit_cnt_d   = 8'h00;
      overflow_d  = 1'b0;
    end
  end

  assign fifo_rd   = fifo_rd_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;

endmodule
